// File: rtl/csr_file_if.sv
// CSR instruction-path bus between decode/execute and the machine-mode CSR file.
// The requester drives address, access type and operand; the CSR file returns data and an illegal flag.
interface csr_file_if;
  logic [11:0] number;
  logic [1:0]  access_type;
  logic [31:0] in;
  logic [31:0] out;
  logic        illegal;

  modport master (output number, access_type, in, input out, illegal);
  modport slave  (input number, access_type, in, output out, illegal);
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap entry/return state, live mip, 64-bit cycle/instret counters
// with inhibit and read-only user shadows, and illegal-access detection.
module csr_file #(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter bit          VECTORED = 1'b1,
  parameter bit          COUNTERS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  csr_file_if.slave   bus,
  input  logic        external_interrupt,
  input  logic        timer_interrupt,
  input  logic        software_interrupt,
  input  logic        exception,
  input  logic [30:0] exception_cause,
  input  logic [31:0] trap_value,
  input  logic        handle_trap,
  input  logic        exit_trap,
  input  logic [31:0] current_pc,
  input  logic        retire,
  output logic [31:0] trap_pc,
  output logic [31:0] ret_pc,
  output logic        interrupted
);

  localparam logic [1:0] CSR_READ_ONLY = 2'd0;
  localparam logic [1:0] CSR_WRITE     = 2'd1;
  localparam logic [1:0] CSR_SET       = 2'd2;
  localparam logic [1:0] CSR_CLEAR     = 2'd3;

  localparam logic [11:0] A_MSTATUS    = 12'h300;
  localparam logic [11:0] A_MISA       = 12'h301;
  localparam logic [11:0] A_MIE        = 12'h304;
  localparam logic [11:0] A_MTVEC      = 12'h305;
  localparam logic [11:0] A_MCOUNTINH  = 12'h320;
  localparam logic [11:0] A_MSCRATCH   = 12'h340;
  localparam logic [11:0] A_MEPC       = 12'h341;
  localparam logic [11:0] A_MCAUSE     = 12'h342;
  localparam logic [11:0] A_MTVAL      = 12'h343;
  localparam logic [11:0] A_MIP        = 12'h344;
  localparam logic [11:0] A_MCYCLE     = 12'hB00;
  localparam logic [11:0] A_MINSTRET   = 12'hB02;
  localparam logic [11:0] A_MCYCLEH    = 12'hB80;
  localparam logic [11:0] A_MINSTRETH  = 12'hB82;
  localparam logic [11:0] A_CYCLE      = 12'hC00;
  localparam logic [11:0] A_INSTRET    = 12'hC02;
  localparam logic [11:0] A_CYCLEH     = 12'hC80;
  localparam logic [11:0] A_INSTRETH   = 12'hC82;
  localparam logic [11:0] A_MVENDORID  = 12'hF11;
  localparam logic [11:0] A_MARCHID    = 12'hF12;
  localparam logic [11:0] A_MIMPID     = 12'hF13;
  localparam logic [11:0] A_MHARTID    = 12'hF14;

  localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;

  function automatic logic [31:0] csr_operand(input logic [1:0]  op,
                                              input logic [31:0] cur,
                                              input logic [31:0] val);
    case (op)
      CSR_SET:   return cur | val;
      CSR_CLEAR: return cur & ~val;
      default:   return val;
    endcase
  endfunction

  // MODE is WARL: only direct (0) or, when supported, vectored (1) survive.
  function automatic logic mtvec_mode_warl(input logic [1:0] mode);
    return VECTORED && (mode == 2'b01);
  endfunction

  logic        status_mie, status_mpie;
  logic        ie_mei, ie_mti, ie_msi;
  logic [29:0] mtvec_base;
  logic        mtvec_mode;
  logic [29:0] mepc;
  logic [31:0] mcause, mtval, mscratch;
  logic [63:0] mcycle, minstret;
  logic        inhibit_cy, inhibit_ir;

  logic [31:0] rdata, wr_data;
  logic        mapped, wr_req, wr_en;
  logic        mei, mti, msi, any_int;
  logic [3:0]  int_code;
  logic [30:0] trap_code;
  logic [31:0] tvec;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^current_pc[1:0];

  always_comb begin
    mapped = 1'b1;
    rdata  = '0;
    case (bus.number)
      A_MSTATUS:   rdata = {24'b0, status_mpie, 3'b0, status_mie, 3'b0};
      A_MISA:      rdata = MISA_VALUE;
      A_MIE:       rdata = {20'b0, ie_mei, 3'b0, ie_mti, 3'b0, ie_msi, 3'b0};
      A_MTVEC:     rdata = {mtvec_base, 1'b0, mtvec_mode};
      A_MSCRATCH:  rdata = mscratch;
      A_MEPC:      rdata = {mepc, 2'b00};
      A_MCAUSE:    rdata = mcause;
      A_MTVAL:     rdata = mtval;
      A_MIP:       rdata = {20'b0, external_interrupt, 3'b0, timer_interrupt, 3'b0,
                            software_interrupt, 3'b0};
      A_MVENDORID, A_MARCHID, A_MIMPID: rdata = '0;
      A_MHARTID:   rdata = HART_ID;
      A_MCOUNTINH: if (COUNTERS) rdata = {29'b0, inhibit_ir, 1'b0, inhibit_cy};
                   else mapped = 1'b0;
      A_MCYCLE, A_CYCLE:       if (COUNTERS) rdata = mcycle[31:0];    else mapped = 1'b0;
      A_MCYCLEH, A_CYCLEH:     if (COUNTERS) rdata = mcycle[63:32];   else mapped = 1'b0;
      A_MINSTRET, A_INSTRET:   if (COUNTERS) rdata = minstret[31:0];  else mapped = 1'b0;
      A_MINSTRETH, A_INSTRETH: if (COUNTERS) rdata = minstret[63:32]; else mapped = 1'b0;
      default:     mapped = 1'b0;
    endcase
  end

  // Unmapped addresses read as zero; writes into the 0b11 read-only quadrant are rejected.
  always_comb begin
    wr_req      = (bus.access_type != CSR_READ_ONLY);
    bus.illegal = !mapped || (wr_req && (bus.number[11:10] == 2'b11));
    bus.out     = rdata;
    wr_data     = csr_operand(bus.access_type, rdata, bus.in);
    wr_en       = wr_req && !bus.illegal && !handle_trap && !exit_trap;
  end

  always_comb begin
    mei         = external_interrupt & ie_mei;
    mti         = timer_interrupt & ie_mti;
    msi         = software_interrupt & ie_msi;
    any_int     = mei | mti | msi;
    interrupted = status_mie & any_int;
    int_code    = 4'd0;
    if (status_mie && mei)      int_code = 4'd11;
    else if (status_mie && msi) int_code = 4'd3;
    else if (status_mie && mti) int_code = 4'd7;
    trap_code   = interrupted ? {27'b0, int_code} : exception_cause;
    tvec        = {mtvec_base, 2'b00};
    trap_pc     = tvec;
    if (mtvec_mode && interrupted && !exception)
      trap_pc = tvec + {26'b0, int_code, 2'b00};
    ret_pc      = {mepc, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      ie_mei      <= 1'b0;
      ie_mti      <= 1'b0;
      ie_msi      <= 1'b0;
      mtvec_base  <= '0;
      mtvec_mode  <= 1'b0;
      mepc        <= '0;
      mcause      <= '0;
      mtval       <= '0;
      mscratch    <= '0;
      inhibit_cy  <= 1'b0;
      inhibit_ir  <= 1'b0;
    end else if (handle_trap) begin
      mepc        <= current_pc[31:2];
      status_mpie <= status_mie;
      status_mie  <= 1'b0;
      mtval       <= trap_value;
      mcause      <= {!exception, trap_code};
    end else if (exit_trap) begin
      status_mie  <= status_mpie;
      status_mpie <= 1'b1;
    end else if (wr_en) begin
      case (bus.number)
        A_MSTATUS: begin
          status_mpie <= wr_data[7];
          status_mie  <= wr_data[3];
        end
        A_MIE: begin
          ie_mei <= wr_data[11];
          ie_mti <= wr_data[7];
          ie_msi <= wr_data[3];
        end
        A_MTVEC: begin
          mtvec_base <= wr_data[31:2];
          mtvec_mode <= mtvec_mode_warl(wr_data[1:0]);
        end
        A_MSCRATCH:  mscratch <= wr_data;
        A_MEPC:      mepc     <= wr_data[31:2];
        A_MCAUSE:    mcause   <= wr_data;
        A_MTVAL:     mtval    <= wr_data;
        A_MCOUNTINH: begin
          inhibit_cy <= wr_data[0];
          inhibit_ir <= wr_data[2];
        end
        default: ;
      endcase
    end
  end

  // A CSR write to one half replaces it and suppresses that counter's increment for the cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_en && bus.number == A_MCYCLE)        mcycle[31:0]  <= wr_data;
      else if (wr_en && bus.number == A_MCYCLEH)  mcycle[63:32] <= wr_data;
      else if (COUNTERS && !inhibit_cy)           mcycle        <= mcycle + 64'd1;

      if (wr_en && bus.number == A_MINSTRET)      minstret[31:0]  <= wr_data;
      else if (wr_en && bus.number == A_MINSTRETH) minstret[63:32] <= wr_data;
      else if (COUNTERS && !inhibit_ir && retire) minstret        <= minstret + 64'd1;
    end
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR file: next generation of the core's CSR unit.
- Adds:
  - optional vectored trap entry
  - a live mip view
  - 64-bit mcycle/minstret counters with mcountinhibit and read-only user shadows
  - illegal-access detection
  - a parametrised hart ID
- Sits beside the decode/execute stage.
- Is addressed by the CSR instruction path and the trap/return control.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14).
- VECTORED, 1, 1 allows mtvec MODE=1 (vectored); 0 forces MODE to read as 0.
- COUNTERS, 1, 1 implements mcycle/minstret/mcountinhibit and their shadows; 0 makes those addresses unmapped (illegal).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- number  in  12  CSR address
- access_type  in  2  csr.h encodings: CSR_READ_ONLY, CSR_WRITE, CSR_SET, CSR_CLEAR
- in  32  in  write operand
- out  out  32  current CSR value (combinational)
- illegal  out  1  access is illegal (combinational)
- external_interrupt, timer_interrupt, software_interrupt  in  1 each  level-sensitive pending lines
- exception  in  1  trap being taken is an exception
- exception_cause  in  31  exception code
- trap_value  in  32  value for mtval
- handle_trap  in  1  take trap this cycle
- exit_trap  in  1  mret this cycle
- current_pc  in  32  PC of trapping instruction
- retire  in  1  one instruction retires this cycle
- trap_pc  out  32  trap entry address (combinational)
- ret_pc  out  32  {mepc[31:2],2'b0}
- interrupted  out  1  enabled interrupt pending

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: all of the following clear to 0:
  - mstatus.MIE/MPIE, mie.MEIE/MTIE/MSIE
  - mtvec (base and mode), mepc, mcause, mtval, mscratch
  - mcycle, minstret, mcountinhibit
- Outputs after reset: trap_pc=0, ret_pc=0, interrupted=0.

CSR map and read values:
- misa = 0x40000100. mvendorid, marchid, mimpid = 0. mhartid = HART_ID.
- mstatus: only bits 7 (MPIE) and 3 (MIE) are stored; all other bits read 0. mie uses bits 11, 7, 3.
- mip (0x344): bit11 = external_interrupt, bit7 = timer_interrupt, bit3 = software_interrupt. Read-only; writes are ignored and are not illegal.
- mtvec: base in [31:2], MODE in [1:0]. MODE is WARL: a written value of 1 is stored only if VECTORED=1; any other value stores 0.
- Counters:
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82 are read/write.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82 are read-only shadows.
  - mcountinhibit 0x320: bits 0 (CY) and 2 (IR) are stored; other bits read 0.

Write operand and illegal accesses:
- next = in (CSR_WRITE), out|in (CSR_SET), out&~in (CSR_CLEAR).
- A write occurs when access_type != CSR_READ_ONLY.
- illegal=1 when either:
  - the address is unmapped, or
  - a write is attempted and number[11:10]==2'b11.
- An illegal access updates no state; out reads 0 for unmapped addresses.

Update priority per cycle: handle_trap > exit_trap > CSR write.
- handle_trap:
  - mepc <= current_pc[31:2]; MPIE <= MIE; MIE <= 0; mtval <= trap_value.
  - mcause[31] <= !exception.
  - mcause[30:0] <= 11 if MEI enabled+pending, else 3 if MSI, else 7 if MTI, else exception_cause. Each interrupt source is qualified by MIE.
- exit_trap: MIE <= MPIE; MPIE <= 1.

Interrupts:
- interrupted = MIE && (ext&MEIE || tim&MTIE || sw&MSIE).

trap_pc (combinational, valid in the handle_trap cycle):
- Equals {base,2'b0} + 4*icause when MODE=1 && interrupted && !exception; icause is the priority-selected code above.
- Equals {base,2'b0} otherwise.
- 32-bit add; wraps mod 2^32.

Counters:
- mcycle += 1 each cycle unless CY=1. minstret += retire unless IR=1.
- Both are 64-bit and wrap from 2^64-1 to 0, with the carry propagating from the low half into the high half.
- A CSR write to either half of a counter replaces that half with next; the other half holds, and that counter does not increment that cycle.
- Counters keep running during handle_trap/exit_trap cycles.
- mcountinhibit takes effect from the cycle after it is written.
- A CSR read returns the pre-increment value of the current cycle.
- Reset asserted mid-count clears both counters on that edge.

Test Plan:
- Reset, then read 0x300/0x304/0x305/0xB00 at the first access -> out=0, interrupted=0, trap_pc=0; read 0xF14 with HART_ID=3 -> 3.
- Write mtvec=0x0000_1001, mstatus=0x8, mie=0x80; raise timer_interrupt -> interrupted=1, trap_pc=0x0000_101C. Pulse handle_trap with current_pc=0x200 -> mcause=0x8000_0007, mepc=0x200, mstatus=0x80. exit_trap -> mstatus=0x88.
- Set MEIE+MTIE, assert both ext and timer lines, handle_trap -> mcause=0x8000_000B. Then handle_trap with exception=1, cause=2, MODE=1 -> trap_pc=base, mcause=2.
- Write mcycle=0xFFFF_FFFE, mcycleh=0; run 3 cycles -> mcycleh=1, mcycle=0x1. Set mcountinhibit=0x5 -> mcycle/minstret hold while retire=1.
- Write 0xC00 via CSR_WRITE -> illegal=1, counters unaffected. Read unmapped 0x7C0 -> illegal=1, out=0. Write mip=0xFFFF_FFFF -> illegal=0, mip still mirrors the input lines.
- VECTORED=0: write mtvec=0x1001 -> read 0x1000; interrupt trap_pc=0x1000. Simultaneous handle_trap and exit_trap -> only the trap effects occur.
